// File: rtl/clock_generate_if.sv
// clock_generate_if
//   Groups the divider outputs into one bundle.
//   o_slow_25M_clk : divided clock, registered, 50 % duty
//   o_rise_pulse   : one fast-cycle strobe in the first high cycle of o_slow_25M_clk
//   o_fall_pulse   : one fast-cycle strobe in the first low cycle of o_slow_25M_clk
//   master : the divider (drives the outputs)
//   slave  : downstream logic (consumes the outputs)
interface clock_generate_if;
  logic o_slow_25M_clk;
  logic o_rise_pulse;
  logic o_fall_pulse;

  modport master (
    output o_slow_25M_clk,
    output o_rise_pulse,
    output o_fall_pulse
  );

  modport slave (
    input o_slow_25M_clk,
    input o_rise_pulse,
    input o_fall_pulse
  );
endinterface

// File: rtl/clock_generate.sv
// clock_generate
//   Free-running synchronous divider: produces i_fast_50M_clk / DIV as a
//   registered square wave, plus fast-domain edge strobes aligned with the
//   first cycle of each new output level.
//   Parameters:
//     DIV            : fast cycles per output period, even and >= 2
//   Ports:
//     i_fast_50M_clk : fast source clock, all state changes on its rising edge
//     i_rst          : synchronous active-high reset
//     bus            : clock_generate_if master (o_slow_25M_clk, o_rise_pulse, o_fall_pulse)
module clock_generate #(
  parameter int DIV = 2
) (
  input  logic             i_fast_50M_clk,
  input  logic             i_rst,
  clock_generate_if.master bus
);

  localparam int HALF = DIV / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  // Reject ratios that cannot give a 50 % duty square wave.
  if ((DIV < 2) || ((DIV % 2) != 0)) begin : g_bad_div
    $error("clock_generate: DIV must be even and >= 2");
  end

  logic [CW-1:0] cnt_r;
  logic          slow_r;
  logic          rise_r;
  logic          fall_r;

  // Half-period counter, output toggle flop and edge strobes.
  // The strobes are computed from the pre-toggle value so they land in the
  // same cycle as the new output level; reset never produces a strobe.
  always_ff @(posedge i_fast_50M_clk) begin
    if (i_rst) begin
      cnt_r  <= CNT_ZERO;
      slow_r <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r  <= CNT_ZERO;
      slow_r <= ~slow_r;
      rise_r <= ~slow_r;
      fall_r <= slow_r;
    end else begin
      cnt_r  <= cnt_r + CNT_ONE;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end
  end

  // Outputs come straight from flops: no logic on the clock path.
  assign bus.o_slow_25M_clk = slow_r;
  assign bus.o_rise_pulse   = rise_r;
  assign bus.o_fall_pulse   = fall_r;

endmodule

// File: tb/tb_clock_generate.sv
`timescale 1ns/1ps
module tb_clock_generate;

  logic clk;
  logic rst [3];
  int   k [3];
  int   half [3];
  int   total;
  int   bad;

  clock_generate_if if2 ();
  clock_generate_if if4 ();
  clock_generate_if if6 ();

  clock_generate #(.DIV(2)) u_d2 (.i_fast_50M_clk(clk), .i_rst(rst[0]), .bus(if2.master));
  clock_generate #(.DIV(4)) u_d4 (.i_fast_50M_clk(clk), .i_rst(rst[1]), .bus(if4.master));
  clock_generate #(.DIV(6)) u_d6 (.i_fast_50M_clk(clk), .i_rst(rst[2]), .bus(if6.master));

  wire [2:0] slow_w = {if6.o_slow_25M_clk, if4.o_slow_25M_clk, if2.o_slow_25M_clk};
  wire [2:0] rise_w = {if6.o_rise_pulse, if4.o_rise_pulse, if2.o_rise_pulse};
  wire [2:0] fall_w = {if6.o_fall_pulse, if4.o_fall_pulse, if2.o_fall_pulse};

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Reference: kk = rising edges since reset was last seen high.
  // Output is high during half-periods with odd index (kk / h).
  function automatic logic exp_slow(input int kk, input int h);
    return (kk > 0) && (((kk / h) % 2) == 1);
  endfunction
  function automatic logic exp_rise(input int kk, input int h);
    return (kk > 0) && ((kk % h) == 0) && (((kk / h) % 2) == 1);
  endfunction
  function automatic logic exp_fall(input int kk, input int h);
    return (kk > 0) && ((kk % h) == 0) && (((kk / h) % 2) == 0);
  endfunction

  // Advance one fast cycle; return at the falling edge (sample/drive point).
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) k[i] = rst[i] ? 0 : k[i] + 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) rst[i] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (slow_w[i] !== 1'b0 || rise_w[i] !== 1'b0 || fall_w[i] !== 1'b0) begin
          bad++;
          $display("FAIL reset dut%0d: slow=%b rise=%b fall=%b required 0 0 0", i, slow_w[i], rise_w[i], fall_w[i]);
        end
      end
    end
  endtask

  task automatic test_release_div2();
    int t_rise, t_fall, t_prev_rise, nr, nf, per_bad, hi_bad, lo_bad;
    logic prev;
    t_rise = -1; t_fall = -1; t_prev_rise = -1;
    nr = 0; nf = 0; per_bad = 0; hi_bad = 0; lo_bad = 0;
    prev = 1'b0;
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    tick();
    total++;
    if (slow_w[0] !== 1'b1 || rise_w[0] !== 1'b1) begin
      bad++;
      $display("FAIL div2_first_edge: slow=%b rise=%b required 1 1", slow_w[0], rise_w[0]);
    end
    prev = slow_w[0];
    t_rise = $time; t_prev_rise = $time;
    nr = 1;
    for (int c = 1; c < 20000; c++) begin
      tick();
      if (rise_w[0] === 1'b1) nr++;
      if (fall_w[0] === 1'b1) nf++;
      if (prev === 1'b0 && slow_w[0] === 1'b1) begin
        t_rise = $time;
        if (t_rise - t_prev_rise != 200) per_bad++;
        if (t_fall >= 0 && t_rise - t_fall != 100) lo_bad++;
        t_prev_rise = t_rise;
      end
      if (prev === 1'b1 && slow_w[0] === 1'b0) begin
        t_fall = $time;
        if (t_fall - t_rise != 100) hi_bad++;
      end
      prev = slow_w[0];
      for (int i = 0; i < 3; i++) begin
        total++;
        if (slow_w[i] !== exp_slow(k[i], half[i]) || rise_w[i] !== exp_rise(k[i], half[i]) ||
            fall_w[i] !== exp_fall(k[i], half[i])) begin
          bad++;
          $display("FAIL run dut%0d k=%0d: slow/rise/fall=%b%b%b required %b%b%b", i, k[i],
                   slow_w[i], rise_w[i], fall_w[i],
                   exp_slow(k[i], half[i]), exp_rise(k[i], half[i]), exp_fall(k[i], half[i]));
        end
      end
    end
    total++;
    if (per_bad != 0 || hi_bad != 0 || lo_bad != 0) begin
      bad++;
      $display("FAIL div2_timing: period_err=%0d high_err=%0d low_err=%0d required 0 0 0", per_bad, hi_bad, lo_bad);
    end
    total++;
    if (nr - nf > 1 || nf - nr > 1 || nr != 10000) begin
      bad++;
      $display("FAIL div2_counts: rises=%0d falls=%0d required 10000 and diff<=1", nr, nf);
    end
  endtask

  task automatic test_div4();
    int nr;
    nr = 0;
    rst[1] = 1'b1; tick(); rst[1] = 1'b0;
    tick();
    total++;
    if (slow_w[1] !== 1'b0 || rise_w[1] !== 1'b0) begin
      bad++;
      $display("FAIL div4_edge1: slow=%b rise=%b required 0 0", slow_w[1], rise_w[1]);
    end
    tick();
    total++;
    if (slow_w[1] !== 1'b1 || rise_w[1] !== 1'b1) begin
      bad++;
      $display("FAIL div4_edge2: slow=%b rise=%b required 1 1", slow_w[1], rise_w[1]);
    end
    for (int c = 0; c < 40; c++) begin
      tick();
      if (rise_w[1] === 1'b1) nr++;
      total++;
      if (slow_w[1] !== exp_slow(k[1], 2) || rise_w[1] !== exp_rise(k[1], 2)) begin
        bad++;
        $display("FAIL div4_run k=%0d: slow=%b rise=%b required %b %b", k[1], slow_w[1], rise_w[1],
                 exp_slow(k[1], 2), exp_rise(k[1], 2));
      end
    end
    total++;
    if (nr != 10) begin
      bad++;
      $display("FAIL div4_rise_count: got %0d required 10", nr);
    end
  endtask

  task automatic test_mid_reset_div4();
    bit found;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      if (rise_w[1] === 1'b1) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL mid_reset_wait: no rise pulse within 10 cycles, required one");
    end
    rst[1] = 1'b1; tick(); rst[1] = 1'b0;
    total++;
    if (slow_w[1] !== 1'b0 || fall_w[1] !== 1'b0 || rise_w[1] !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_force: slow=%b rise=%b fall=%b required 0 0 0", slow_w[1], rise_w[1], fall_w[1]);
    end
    tick();
    total++;
    if (slow_w[1] !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_rel1: slow=%b required 0", slow_w[1]);
    end
    tick();
    total++;
    if (slow_w[1] !== 1'b1 || rise_w[1] !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_rel2: slow=%b rise=%b required 1 1", slow_w[1], rise_w[1]);
    end
  endtask

  task automatic test_strobe_div6();
    int nr, nf, errs;
    logic prev;
    nr = 0; nf = 0; errs = 0;
    rst[2] = 1'b1; tick(); rst[2] = 1'b0;
    prev = slow_w[2];
    for (int c = 0; c < 600; c++) begin
      tick();
      if (rise_w[2] === 1'b1) begin
        nr++;
        if (!(prev === 1'b0 && slow_w[2] === 1'b1)) errs++;
      end
      if (fall_w[2] === 1'b1) begin
        nf++;
        if (!(prev === 1'b1 && slow_w[2] === 1'b0)) errs++;
      end
      if (rise_w[2] === 1'b1 && fall_w[2] === 1'b1) errs++;
      if (prev !== slow_w[2] && rise_w[2] !== 1'b1 && fall_w[2] !== 1'b1) errs++;
      prev = slow_w[2];
    end
    total++;
    if (nr != 100 || nf != 100) begin
      bad++;
      $display("FAIL div6_counts: rises=%0d falls=%0d required 100 100", nr, nf);
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL div6_alignment: errors=%0d required 0", errs);
    end
  endtask

  task automatic test_random_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) rst[i] = ($urandom_range(0, 39) == 0);
      tick();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (slow_w[i] !== exp_slow(k[i], half[i]) || rise_w[i] !== exp_rise(k[i], half[i]) ||
            fall_w[i] !== exp_fall(k[i], half[i])) begin
          bad++;
          $display("FAIL random dut%0d k=%0d: slow/rise/fall=%b%b%b required %b%b%b", i, k[i],
                   slow_w[i], rise_w[i], fall_w[i],
                   exp_slow(k[i], half[i]), exp_rise(k[i], half[i]), exp_fall(k[i], half[i]));
        end
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    half[0] = 1; half[1] = 2; half[2] = 3;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      k[i] = 0;
    end
    @(negedge clk);
    test_reset();
    test_release_div2();
    test_div4();
    test_mid_reset_div4();
    test_strobe_div6();
    test_random_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_generate.md
# clock_generate

Synchronous clock divider that derives a half-rate clock from the 50 MHz system clock (50 MHz in, 25 MHz out at default settings). The output is a registered, 50 %-duty square wave for downstream logic (e.g. pixel/video timing) that needs a slower clock domain. It also provides single-cycle edge strobes in the fast domain, so fast-domain logic can align with slow-clock edges without sampling the divided clock.

## Interface
- DIV, default 2: integer division ratio, fast cycles per output period; must be even and ≥ 2; any other value is an elaboration error.
- HALF (derived, DIV/2): fast cycles per output half-period.
- CW (derived, max(1, $clog2(HALF))): half-period counter width.

- i_fast_50M_clk  input  1  fast source clock (50 MHz nominal); all state updates on its rising edge
- i_rst  input  1  reset; one clock; reset is synchronous and active-high
- o_slow_25M_clk  output  1  divided clock, registered, frequency = f(i_fast_50M_clk)/DIV, 50 % duty
- o_rise_pulse  output  1  one fast-cycle strobe, high in the fast cycle in which o_slow_25M_clk is 1 for the first time in a high phase
- o_fall_pulse  output  1  one fast-cycle strobe, high in the fast cycle in which o_slow_25M_clk is 0 for the first time in a low phase (not asserted by reset)

## Operation
- State: half-period counter cnt[CW-1:0], output register slow_q, strobe registers.
- Reset (i_rst = 1 at a rising edge): cnt ← 0, slow_q ← 0, o_rise_pulse ← 0, o_fall_pulse ← 0. Reset dominates all other activity.
- Normal rising edge (i_rst = 0):
  - if cnt == HALF-1: cnt ← 0, slow_q ← ~slow_q; o_rise_pulse ← ~slow_q; o_fall_pulse ← slow_q.
  - else: cnt ← cnt+1; both strobes ← 0.
- DIV = 2: HALF-1 = 0, so slow_q toggles on every fast rising edge; cnt stays 0.
- o_slow_25M_clk = slow_q, driven directly from a flop, with no combinational logic on the output path (glitch-free).
- No enable and no phase adjust: the divider free-runs whenever reset is low.
- Counter arithmetic is modulo HALF; cnt never exceeds HALF-1.

## Timing
- Reset values: o_slow_25M_clk = 0, o_rise_pulse = 0, o_fall_pulse = 0.
- Reset asserted mid-operation: at the first rising edge with i_rst = 1, the output goes to 0 and the counter clears, regardless of phase. No strobe is produced for this forced transition.
- Reset is held: outputs stay at reset values for every edge.
- Release: the first toggle to 1 occurs at the HALF-th rising edge with i_rst = 0. For DIV = 2 this is the first edge after release.
- Steady state: o_slow_25M_clk is high for exactly HALF fast cycles, then low for HALF fast cycles; period = DIV fast cycles.
- With a 100-unit fast period and DIV = 2, the output period is 200 units.
- Strobes are registered together with slow_q. Each strobe is high for exactly one fast cycle, coinciding with the first fast cycle of the new output level. They are never high simultaneously.
- Latency from reset deassertion to the first o_rise_pulse: HALF fast cycles.

## Test plan
- Reset check, DIV = 2: hold i_rst = 1 for 2 edges -> o_slow_25M_clk = 0, both strobes 0.
- Release, DIV = 2, 100-unit clock: deassert i_rst on a falling edge -> output goes 1 at the next rising edge, then toggles every rising edge for 20000 cycles. Measured period must be 200 units, high time 100, low time 100; rise and fall counts must differ by at most 1.
- DIV = 4: after release, output low for 1 more edge, goes high at the 2nd edge, then 2 high / 2 low repeating -> output period 4 fast cycles. o_rise_pulse must be high once per 4 cycles, aligned with the first high cycle.
- Mid-operation reset, DIV = 4: assert i_rst for 1 cycle while output = 1 and cnt = 0 -> output 0 at that edge, no o_fall_pulse. After release, the first high occurs exactly 2 edges later.
- Strobe integrity, DIV = 6 over 600 cycles: exactly 100 rise pulses and 100 fall pulses, never simultaneous, each 1 cycle wide. Each pulse must coincide with the first cycle of the new output level.
- Elaboration, DIV = 3 or DIV = 0: must fail with an error.
